// File: rtl/fifo_pkg.sv
// Types and derived widths for the FIFO read/write controllers.
package fifo_pkg;
  import global_pkg::*;

  localparam int DEPTH     = VECTOR_SIZE;
  localparam int ADDR_W    = $clog2(VECTOR_SIZE);
  localparam int BUF_DEPTH = 2;

  // Extra MSB is the wrap bit that lets the push side tell full from empty.
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        cnt_t;
endpackage

// File: rtl/global_pkg.sv
// Project-wide sizing shared by the FIFO memory vector and its controllers.
package global_pkg;
  localparam int VECTOR_SIZE = 8;
  localparam int DATA_W      = 8;
endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer; the head register drives the consumer data directly.
module fifo_out_buf
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  wr_en,
  input  data_t wr_data,
  input  logic  rd_fire,
  output data_t head,
  output cnt_t  cnt
);

  data_t head_reg;
  data_t tail_reg;
  cnt_t  cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
      cnt_reg  <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else begin
      case ({wr_en, rd_fire})
        2'b10: begin
          if (cnt_reg == 2'd0) head_reg <= wr_data;
          else                 tail_reg <= wr_data;
          cnt_reg <= cnt_reg + 2'd1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          cnt_reg  <= cnt_reg - 2'd1;
        end
        2'b11: begin
          // Capture and fire together: count holds, the queue shifts by one.
          if (cnt_reg == 2'd2) begin
            head_reg <= tail_reg;
            tail_reg <= wr_data;
          end else begin
            head_reg <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = head_reg;
  assign cnt  = cnt_reg;

endmodule

// File: rtl/fifo_pop_engine.sv
// Read-side FIFO controller: pop pointer, read issue, latency absorption and
// a valid/ready consumer port.
module fifo_pop_engine
  import fifo_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  ptr_t     wr_ptr,
  input  data_t    ram_data,
  output logic     rd_en,
  output address_t count_pop,
  output ptr_t     rd_ptr,
  output logic     empty,
  output ptr_t     level,
  output logic     pop_valid,
  input  logic     pop_ready,
  output data_t    pop_data
);

  ptr_t       rd_ptr_reg;
  logic       inflight_reg;
  cnt_t       buf_cnt;
  logic       fire;
  logic [2:0] occupancy;

  assign fire      = pop_valid & pop_ready;
  assign empty     = (rd_ptr_reg == wr_ptr);
  assign level     = wr_ptr - rd_ptr_reg;
  assign count_pop = rd_ptr_reg[ADDR_W-1:0];
  assign rd_ptr    = rd_ptr_reg;

  // Words already owed to the buffer after this edge; at most two may be outstanding.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight_reg} - {2'b00, fire};
  assign rd_en     = !rst & !empty & !flush & (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
    end else if (flush) begin
      rd_ptr_reg   <= wr_ptr;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
    end
  end

  fifo_out_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (inflight_reg),
    .wr_data (ram_data),
    .rd_fire (fire),
    .head    (pop_data),
    .cnt     (buf_cnt)
  );

  assign pop_valid = (buf_cnt != 2'd0);

endmodule
